// File: rtl/ama_riscv_branch_predictor_pkg.sv
// Shared types and defaults for the gshare/bimodal branch predictor.
// Includes the 2-bit saturating counter update helper.
package ama_riscv_branch_predictor_pkg;

   typedef enum logic [1:0] {
      BP_SNT = 2'b00,
      BP_WNT = 2'b01,
      BP_WT  = 2'b10,
      BP_ST  = 2'b11
   } bp_cnt_t;

   localparam int BP_PHT_ENTRIES_DEF = 64;
   localparam int BP_GHR_BITS_DEF    = 4;

   function automatic bp_cnt_t bp_cnt_next(
      input bp_cnt_t cnt,
      input logic    taken
   );
      bp_cnt_t nxt;
      nxt = cnt;
      if (taken && (cnt != BP_ST))
         nxt = bp_cnt_t'(cnt + 2'd1);
      else if (!taken && (cnt != BP_SNT))
         nxt = bp_cnt_t'(cnt - 2'd1);
      return nxt;
   endfunction

endpackage

// File: rtl/ama_riscv_bp_pht.sv
// Pattern history table: one async read port, one sync saturating update.
// Reads see the pre-update value when read and write hit the same entry.
module ama_riscv_bp_pht
   import ama_riscv_branch_predictor_pkg::*;
#(
   parameter int         ENTRIES  = BP_PHT_ENTRIES_DEF,
   parameter logic [1:0] CNT_INIT = 2'b01
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [$clog2(ENTRIES)-1:0] rd_idx,
   output bp_cnt_t                    rd_cnt,
   input  logic                       wr_en,
   input  logic [$clog2(ENTRIES)-1:0] wr_idx,
   input  logic                       wr_taken
);

   bp_cnt_t pht [ENTRIES];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++)
            pht[i] <= bp_cnt_t'(CNT_INIT);
      end else if (wr_en) begin
         pht[wr_idx] <= bp_cnt_next(pht[wr_idx], wr_taken);
      end
   end

   assign rd_cnt = pht[rd_idx];

endmodule

// File: rtl/ama_riscv_branch_predictor.sv
// Direction predictor: predicts the ID branch, checks it in EX, trains at
// resolution with non-speculative global history, and counts branches/mispredicts.
module ama_riscv_branch_predictor
   import ama_riscv_branch_predictor_pkg::*;
#(
   parameter int         PHT_ENTRIES = BP_PHT_ENTRIES_DEF,
   parameter int         GHR_BITS    = BP_GHR_BITS_DEF,
   parameter logic [1:0] CNT_INIT    = 2'b01
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_id,
   input  logic        branch_inst_id,
   input  logic        stall_id,
   input  logic        flush_ex,
   input  logic        branch_taken_ex,
   output logic        bp_taken,
   output logic        bp_clear,
   output logic [31:0] cnt_branches,
   output logic [31:0] cnt_mispred
);

   localparam int IDX_W = $clog2(PHT_ENTRIES);

   logic [IDX_W-1:0] hist;
   logic [IDX_W-1:0] idx_id;
   logic [IDX_W-1:0] idx_ex;
   logic             valid_ex;
   logic             pred_ex;
   bp_cnt_t          cnt_id;
   logic             unused_bits;

   generate
      if (GHR_BITS > 0) begin : g_ghr
         logic [GHR_BITS-1:0] ghr;
         logic [GHR_BITS-1:0] ghr_nxt;

         if (GHR_BITS == 1) begin : g_one
            assign ghr_nxt = branch_taken_ex;
         end else begin : g_many
            assign ghr_nxt = {ghr[GHR_BITS-2:0], branch_taken_ex};
         end

         // history advances only when a branch resolves in EX
         always_ff @(posedge clk) begin
            if (rst)
               ghr <= '0;
            else if (valid_ex)
               ghr <= ghr_nxt;
         end

         assign hist = IDX_W'(ghr);
      end else begin : g_bimodal
         assign hist = '0;
      end
   endgenerate

   assign idx_id = pc_id[IDX_W+1:2] ^ hist;

   ama_riscv_bp_pht #(
      .ENTRIES  (PHT_ENTRIES),
      .CNT_INIT (CNT_INIT)
   ) u_pht (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (idx_id),
      .rd_cnt   (cnt_id),
      .wr_en    (valid_ex),
      .wr_idx   (idx_ex),
      .wr_taken (branch_taken_ex)
   );

   assign bp_taken = branch_inst_id & cnt_id[1];
   assign bp_clear = valid_ex & (pred_ex ^ branch_taken_ex);

   // a mispredict also kills the wrong-path branch leaving ID
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_ex     <= 1'b0;
         pred_ex      <= 1'b0;
         idx_ex       <= '0;
         cnt_branches <= '0;
         cnt_mispred  <= '0;
      end else begin
         valid_ex <= branch_inst_id & ~stall_id & ~flush_ex & ~bp_clear;
         if (!stall_id) begin
            pred_ex <= bp_taken;
            idx_ex  <= idx_id;
         end
         if (valid_ex) begin
            cnt_branches <= cnt_branches + 32'd1;
            cnt_mispred  <= cnt_mispred + 32'(bp_clear);
         end
      end
   end

   assign unused_bits = ^{pc_id[31:IDX_W+2], pc_id[1:0], cnt_id[0]};

endmodule

// File: tb/tb_ama_riscv_branch_predictor.sv
// Directed bench for the branch predictor: a gshare build (GHR_BITS=4)
// checked against a small reference model, plus a bimodal build (GHR_BITS=0).
module tb_ama_riscv_branch_predictor;

   logic        clk;
   logic        rst;
   logic [31:0] pc_id;
   logic        branch_inst_id;
   logic        stall_id;
   logic        flush_ex;
   logic        branch_taken_ex;

   logic        bp_taken;
   logic        bp_clear;
   logic [31:0] cnt_branches;
   logic [31:0] cnt_mispred;
   logic        bp_taken0;
   logic        bp_clear0;
   logic [31:0] cnt_branches0;
   logic [31:0] cnt_mispred0;

   int n_cmp = 0;
   int n_bad = 0;

   logic [1:0]  m_pht [64];
   logic [3:0]  m_ghr;
   logic        m_vex;
   logic        m_pred;
   logic [5:0]  m_idx;
   logic [31:0] m_nb;
   logic [31:0] m_nm;

   ama_riscv_branch_predictor #(
      .PHT_ENTRIES (64),
      .GHR_BITS    (4),
      .CNT_INIT    (2'b01)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .pc_id           (pc_id),
      .branch_inst_id  (branch_inst_id),
      .stall_id        (stall_id),
      .flush_ex        (flush_ex),
      .branch_taken_ex (branch_taken_ex),
      .bp_taken        (bp_taken),
      .bp_clear        (bp_clear),
      .cnt_branches    (cnt_branches),
      .cnt_mispred     (cnt_mispred)
   );

   ama_riscv_branch_predictor #(
      .PHT_ENTRIES (64),
      .GHR_BITS    (0),
      .CNT_INIT    (2'b01)
   ) dut0 (
      .clk             (clk),
      .rst             (rst),
      .pc_id           (pc_id),
      .branch_inst_id  (branch_inst_id),
      .stall_id        (stall_id),
      .flush_ex        (flush_ex),
      .branch_taken_ex (branch_taken_ex),
      .bp_taken        (bp_taken0),
      .bp_clear        (bp_clear0),
      .cnt_branches    (cnt_branches0),
      .cnt_mispred     (cnt_mispred0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 64; i++) m_pht[i] = 2'b01;
      m_ghr  = '0;
      m_vex  = 1'b0;
      m_pred = 1'b0;
      m_idx  = '0;
      m_nb   = '0;
      m_nm   = '0;
   endtask

   function automatic logic [5:0] m_index(input logic [31:0] pc);
      return pc[7:2] ^ {2'b00, m_ghr};
   endfunction

   // apply inputs, let them settle, compare the gshare build with the model
   task automatic drive(input logic r, input logic [31:0] pc,
                        input logic br, input logic st,
                        input logic fl, input logic tk);
      logic [5:0] ix;
      rst             = r;
      pc_id           = pc;
      branch_inst_id  = br;
      stall_id        = st;
      flush_ex        = fl;
      branch_taken_ex = tk;
      #2;
      ix = m_index(pc);
      chk("m_bp_taken", bp_taken, br & m_pht[ix][1]);
      chk("m_bp_clear", bp_clear, m_vex & (m_pred ^ tk));
      chk("m_cnt_branches", cnt_branches, m_nb);
      chk("m_cnt_mispred", cnt_mispred, m_nm);
   endtask

   task automatic adv();
      logic [5:0] ix;
      logic       bpt;
      logic       clr;
      ix  = m_index(pc_id);
      bpt = branch_inst_id & m_pht[ix][1];
      clr = m_vex & (m_pred ^ branch_taken_ex);
      @(posedge clk);
      if (rst) begin
         m_reset();
      end else begin
         if (m_vex) begin
            if (branch_taken_ex && m_pht[m_idx] != 2'b11)
               m_pht[m_idx] = m_pht[m_idx] + 2'd1;
            else if (!branch_taken_ex && m_pht[m_idx] != 2'b00)
               m_pht[m_idx] = m_pht[m_idx] - 2'd1;
            m_ghr = {m_ghr[2:0], branch_taken_ex};
            m_nb  = m_nb + 32'd1;
            m_nm  = m_nm + 32'(clr);
         end
         m_vex = branch_inst_id & ~stall_id & ~flush_ex & ~clr;
         if (!stall_id) begin
            m_pred = bpt;
            m_idx  = ix;
         end
      end
      #1;
   endtask

   initial begin
      rst             = 1'b1;
      pc_id           = '0;
      branch_inst_id  = 1'b0;
      stall_id        = 1'b0;
      flush_ex        = 1'b0;
      branch_taken_ex = 1'b0;
      @(posedge clk);
      #1;
      m_reset();

      // first prediction after reset, then a taken resolution
      drive(1, 32'h0, 0, 0, 0, 0); adv();
      drive(0, 32'h100, 1, 0, 0, 0);
      chk("rst_clear", bp_clear, 0);
      chk("rst_branches", cnt_branches, 0);
      chk("rst_mispred", cnt_mispred, 0);
      chk("t1_pred", bp_taken, 0);
      chk("t1_pred0", bp_taken0, 0);
      adv();
      drive(0, 32'h0, 0, 0, 0, 1);
      chk("t1_clear", bp_clear, 1);
      adv();

      // bimodal build: counter 10 -> 11 -> 11
      drive(0, 32'h100, 1, 0, 0, 0);
      chk("t1_branches", cnt_branches, 1);
      chk("t1_mispred", cnt_mispred, 1);
      chk("t2_pred_c", bp_taken0, 1);
      adv();
      drive(0, 32'h100, 1, 0, 0, 1);
      chk("t2_clear_d", bp_clear0, 0);
      chk("t2_pred_d", bp_taken0, 1);
      adv();
      drive(0, 32'h100, 1, 0, 0, 1);
      chk("t2_pred_e", bp_taken0, 1);
      chk("t2_clear_e", bp_clear0, 0);
      adv();
      drive(0, 32'h100, 0, 0, 0, 1);
      chk("t2_nonbranch", bp_taken0, 0);
      chk("t2_clear_f", bp_clear0, 0);
      adv();
      drive(0, 32'h0, 0, 0, 0, 0);
      chk("t2_branches0", cnt_branches0, 4);
      chk("t2_mispred0", cnt_mispred0, 1);
      adv();

      // loop T,T,T,N x16 with a bubble so history is current at each read
      drive(1, 32'h0, 0, 0, 0, 0); adv();
      for (int k = 0; k < 16; k++) begin
         for (int j = 0; j < 4; j++) begin
            drive(0, 32'h200, 1, 0, 0, 0); adv();
            drive(0, 32'h0, 0, 0, 0, (j != 3)); adv();
         end
      end
      drive(0, 32'h0, 0, 0, 0, 0);
      chk("t3_branches", cnt_branches, 64);
      chk("t3_mispred", cnt_mispred, 6);
      chk("t3_mispred_le6", 32'(cnt_mispred <= 32'd6), 1);
      adv();

      // stall with a branch in EX and another held in ID
      drive(1, 32'h0, 0, 0, 0, 0); adv();
      drive(0, 32'h300, 1, 0, 0, 0); adv();
      drive(0, 32'h304, 1, 1, 0, 0);
      chk("t4_clear_b", bp_clear, 0);
      adv();
      drive(0, 32'h304, 1, 1, 0, 1);
      chk("t4_clear_c", bp_clear, 0);
      chk("t4_branches_c", cnt_branches, 1);
      adv();
      drive(0, 32'h304, 1, 1, 0, 1);
      chk("t4_clear_d", bp_clear, 0);
      adv();
      drive(0, 32'h304, 1, 0, 0, 1);
      chk("t4_clear_e", bp_clear, 0);
      chk("t4_branches_e", cnt_branches, 1);
      adv();
      drive(0, 32'h0, 0, 0, 0, 0);
      chk("t4_clear_f", bp_clear, 0);
      adv();
      drive(0, 32'h0, 0, 0, 0, 0);
      chk("t4_branches_g", cnt_branches, 2);
      chk("t4_mispred_g", cnt_mispred, 0);
      adv();

      // mispredict and flush both block the ID branch
      drive(1, 32'h0, 0, 0, 0, 0); adv();
      drive(0, 32'h100, 1, 0, 0, 0); adv();
      drive(0, 32'h104, 1, 0, 0, 1);
      chk("t5_clear_b", bp_clear, 1);
      adv();
      drive(0, 32'h0, 0, 0, 0, 1);
      chk("t5_clear_c", bp_clear, 0);
      chk("t5_branches_c", cnt_branches, 1);
      chk("t5_mispred_c", cnt_mispred, 1);
      adv();
      drive(0, 32'h108, 1, 0, 1, 0); adv();
      drive(0, 32'h0, 0, 0, 0, 1);
      chk("t5_clear_e", bp_clear, 0);
      adv();
      drive(0, 32'h0, 0, 0, 0, 0);
      chk("t5_branches_f", cnt_branches, 1);
      adv();

      // same-index read/write, then reset with a branch in flight
      drive(1, 32'h0, 0, 0, 0, 0); adv();
      drive(0, 32'h100, 1, 0, 0, 0); adv();
      drive(0, 32'h100, 1, 0, 0, 1);
      chk("t6_same_idx", bp_taken, 0);
      chk("t6_same_idx0", bp_taken0, 0);
      chk("t6_clear", bp_clear, 1);
      adv();
      drive(0, 32'h104, 1, 1, 0, 0);
      chk("t6_next_read", bp_taken, 1);
      adv();
      drive(0, 32'h100, 1, 1, 0, 0);
      chk("t6_next_read0", bp_taken0, 1);
      adv();
      drive(0, 32'h100, 1, 0, 0, 0); adv();
      drive(1, 32'h0, 0, 0, 0, 1); adv();
      drive(1, 32'h0, 0, 0, 0, 0);
      chk("t6_rst_clear", bp_clear, 0);
      chk("t6_rst_taken", bp_taken, 0);
      chk("t6_rst_branches", cnt_branches, 0);
      chk("t6_rst_mispred", cnt_mispred, 0);
      adv();
      drive(0, 32'h104, 1, 0, 0, 0);
      chk("t6_post_taken", bp_taken, 0);
      chk("t6_post_taken0", bp_taken0, 0);
      chk("t6_post_branches0", cnt_branches0, 0);
      adv();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
